// File: rtl/mig1_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : mig1_fetch_if
// Purpose  : Fetch-unit bundle: ROM port, redirect request and decode handoff.
// Revision : 1.0  initial release
// ============================================================================
interface mig1_fetch_if #(
    parameter int IMEM_ADDR_WIDTH = 8
);
    logic [IMEM_ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]                imem_data;
    logic                       redirect_valid;
    logic [IMEM_ADDR_WIDTH-1:0] redirect_pc;
    logic                       inst_valid;
    logic [31:0]                inst_data;
    logic [IMEM_ADDR_WIDTH-1:0] inst_pc;
    logic                       inst_ready;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redirect_valid,
        input  redirect_pc,
        output inst_valid,
        output inst_data,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redirect_valid,
        output redirect_pc,
        input  inst_valid,
        input  inst_data,
        input  inst_pc,
        output inst_ready
    );
endinterface
`default_nettype wire

// File: rtl/mig1_fetch.sv
`default_nettype none
// ============================================================================
// Module   : mig1_fetch
// Purpose  : Mig1 instruction fetch: credit-based ROM issue, buffer FIFO,
//            valid/ready handoff to decode, branch redirect with flush.
// Options  : MIG1_FETCH_TRACE_EN enables pop/redirect trace and delivered count.
// Revision : 1.0  initial release
// ============================================================================
module mig1_fetch #(
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH      = 4,
    parameter int RESET_PC        = 0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    mig1_fetch_if.master bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [IMEM_ADDR_WIDTH-1:0] c_RESET_PC   = IMEM_ADDR_WIDTH'(RESET_PC);
    localparam logic [IMEM_ADDR_WIDTH-1:0] c_PC_STEP    = IMEM_ADDR_WIDTH'(4);
    localparam logic [IMEM_ADDR_WIDTH-1:0] c_ALIGN_MASK = IMEM_ADDR_WIDTH'(3);
    localparam logic [c_CNT_W:0]           c_DEPTH      = (c_CNT_W + 1)'(FIFO_DEPTH);

    logic [IMEM_ADDR_WIDTH-1:0] r_fetch_pc;
    logic [IMEM_ADDR_WIDTH-1:0] r_pending_pc;
    logic                       r_pending;
    logic [31:0]                r_mem_data [FIFO_DEPTH];
    logic [IMEM_ADDR_WIDTH-1:0] r_mem_pc   [FIFO_DEPTH];
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;
    logic [31:0]                r_last_data;
    logic [IMEM_ADDR_WIDTH-1:0] r_last_pc;

    logic                       w_empty;
    logic                       w_can_issue;
    logic                       w_push;
    logic                       w_pop;
    logic [31:0]                w_head_data;
    logic [IMEM_ADDR_WIDTH-1:0] w_head_pc;
    logic [IMEM_ADDR_WIDTH-1:0] w_redirect_target;

    // Credit counts the in-flight ROM read so a capture can never overflow the FIFO.
    assign w_empty           = (r_count == '0);
    assign w_can_issue       = ({1'b0, r_count} + {{c_CNT_W{1'b0}}, r_pending}) < c_DEPTH;
    assign w_push            = r_pending;
    assign w_pop             = !w_empty && bus.inst_ready;
    assign w_head_data       = r_mem_data[r_rd_ptr];
    assign w_head_pc         = r_mem_pc[r_rd_ptr];
    assign w_redirect_target = bus.redirect_pc & ~c_ALIGN_MASK;

    assign bus.imem_addr  = r_fetch_pc;
    assign bus.inst_valid = !w_empty;
    assign bus.inst_data  = w_empty ? r_last_data : w_head_data;
    assign bus.inst_pc    = w_empty ? r_last_pc   : w_head_pc;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= bus.imem_data;
            r_mem_pc[r_wr_ptr]   <= r_pending_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc   <= c_RESET_PC;
            r_pending_pc <= '0;
            r_pending    <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_last_data  <= '0;
            r_last_pc    <= '0;
        end else begin
            // Remember the visible head so outputs hold steady once the FIFO drains.
            if (!w_empty) begin
                r_last_data <= w_head_data;
                r_last_pc   <= w_head_pc;
            end
            if (bus.redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
                r_pending  <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                r_pending <= w_can_issue;
                if (w_can_issue) begin
                    r_pending_pc <= r_fetch_pc;
                    r_fetch_pc   <= r_fetch_pc + c_PC_STEP;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
        w_push |-> ({1'b0, r_count} < c_DEPTH));
`endif

`ifdef MIG1_FETCH_TRACE_EN
    logic [31:0] r_delivered_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_delivered_cnt <= '0;
        end else begin
            if (w_pop) begin
                $display("fetch: pc=%h inst=%h", w_head_pc, w_head_data);
                r_delivered_cnt <= r_delivered_cnt + 32'd1;
            end
            if (bus.redirect_valid) begin
                $display("fetch: redirect %h flushed %0d", w_redirect_target,
                         r_count - c_CNT_W'(w_pop));
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mig1_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_mig1_fetch
// Purpose  : Scoreboard bench for mig1_fetch against a word-stream model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mig1_fetch;
    localparam int AW = 8;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    mig1_fetch_if #(.IMEM_ADDR_WIDTH(AW)) bus ();

    mig1_fetch #(
        .IMEM_ADDR_WIDTH(AW),
        .FIFO_DEPTH     (4),
        .RESET_PC       (0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    function automatic logic [31:0] rom_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + 32'(a >> 2);
    endfunction

    // Synchronous ROM: word for the address presented on the previous cycle.
    always @(posedge clk) bus.imem_data <= rom_word(bus.imem_addr);

    int checks = 0;
    int failures = 0;
    int hs_since_reset = 0;
    exp_t exp_q[$];
    logic [AW-1:0] gen_pc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: decode sees consecutive words starting at the latest restart point.
    task automatic top_up();
        exp_t e;
        while (exp_q.size() < 16) begin
            e.pc   = gen_pc;
            e.data = rom_word(gen_pc);
            exp_q.push_back(e);
            gen_pc = gen_pc + 8'd4;
        end
    endtask

    task automatic restart_model(input logic [AW-1:0] pc);
        exp_q.delete();
        gen_pc = pc & 8'hFC;
        top_up();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        top_up();
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: got pc %h expected no delivery", bus.inst_pc);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", 32'(bus.inst_pc), 32'(e.pc));
                check("inst_data", bus.inst_data, e.data);
            end
        end
        if (reset) hs_since_reset = 0;
        else if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) hs_since_reset++;
    end

    // Reset for n edges, then check reset state and the cycle-0/1/2 startup timing.
    task automatic reset_seq(input int n);
        tick();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        repeat (n) tick();
        reset = 1'b0;
        restart_model(8'h00);
        @(negedge clk);
        check("rst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_pc", 32'(bus.inst_pc), 32'd0);
        check("rst_data", bus.inst_data, 32'd0);
        tick();
        @(negedge clk);
        check("start_c1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("start_c2_valid", 32'(bus.inst_valid), 32'd1);
        check("start_c2_pc", 32'(bus.inst_pc), 32'd0);
        check("start_c2_data", bus.inst_data, 32'h1000_0000);
    endtask

    task automatic redirect_seq(input logic [AW-1:0] pc, input bit rnd_ready);
        logic [AW-1:0] tgt;
        tgt = pc & 8'hFC;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        if (rnd_ready) bus.inst_ready = ($urandom_range(0, 9) < 7);
        tick();
        bus.redirect_valid = 1'b0;
        restart_model(pc);
        if (rnd_ready) bus.inst_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        check("redir_r1_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        if (rnd_ready) bus.inst_ready = ($urandom_range(0, 9) < 7);
        @(negedge clk);
        check("redir_r2_valid", 32'(bus.inst_valid), 32'd0);
        tick();
        @(negedge clk);
        check("redir_r3_valid", 32'(bus.inst_valid), 32'd1);
        check("redir_r3_pc", 32'(bus.inst_pc), 32'(tgt));
        check("redir_r3_data", bus.inst_data, rom_word(tgt));
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;

        // Startup with ready high: one word per cycle, no gaps.
        reset_seq(2);
        for (int i = 0; i < 12; i++) begin
            tick();
            @(negedge clk);
            check("steady_no_gap", 32'(bus.inst_valid), 32'd1);
        end

        // Decode stalled: issue stops after four credits, head holds.
        bus.inst_ready = 1'b0;
        reset_seq(2);
        bus.inst_ready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("stall_addr", 32'(bus.imem_addr), 32'h10);
        check("stall_head_pc", 32'(bus.inst_pc), 32'h00);
        check("stall_valid", 32'(bus.inst_valid), 32'd1);
        tick();
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("release_no_gap", 32'(bus.inst_valid), 32'd1);
            tick();
        end

        // Redirect to an unaligned target; head popped in cycle R counts once.
        repeat (3) tick();
        @(negedge clk);
        check("pop_at_redirect_valid", 32'(bus.inst_valid), 32'd1);
        redirect_seq(8'h41, 1'b0);

        // Redirect near the top of the address space: PC wraps.
        redirect_seq(8'hF8, 1'b0);
        tick();
        @(negedge clk);
        check("wrap_pc_fc", 32'(bus.inst_pc), 32'hFC);
        tick();
        @(negedge clk);
        check("wrap_pc_00", 32'(bus.inst_pc), 32'h00);
        tick();
        @(negedge clk);
        check("wrap_pc_04", 32'(bus.inst_pc), 32'h04);

        // Back-to-back redirects: the last one wins.
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h80;
        redirect_seq(8'h20, 1'b0);

        // Full FIFO then a one-cycle reset discards everything.
        tick();
        bus.inst_ready = 1'b0;
        repeat (8) tick();
        @(negedge clk);
        check("full_valid", 32'(bus.inst_valid), 32'd1);
        reset_seq(1);
        tick();
        bus.inst_ready = 1'b1;

        // Randomised traffic with occasional redirects and resets.
        for (int i = 0; i < 400; i++) begin
            tick();
            bus.inst_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) begin
                redirect_seq(AW'($urandom_range(0, 255)), 1'b1);
            end else if ($urandom_range(0, 99) == 0) begin
                reset_seq($urandom_range(1, 2));
            end
        end

`ifdef MIG1_FETCH_TRACE_EN
        tick();
        bus.inst_ready = 1'b0;
        tick();
        @(negedge clk);
        check("trace_count", dut.r_delivered_cnt, 32'(hs_since_reset));
`endif

        tick();
        bus.inst_ready = 1'b0;
        repeat (2) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
